// File: rtl/simon_loader_pkg.sv
// Shared types, frame-length helpers and SIMON 96/96 reference vectors for the word loader.
`timescale 1ns/1ps
package simon_loader_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HOLD  = 1'b1
  } slot_state_t;

  typedef enum logic {
    ASM_COLLECT = 1'b0,
    ASM_FULL    = 1'b1
  } asm_state_t;

  function automatic int calc_dw(input int n, input int w);
    return (2 * n) / w;
  endfunction

  function automatic int calc_kw(input int n, input int m, input int w);
    return (m * n) / w;
  endfunction

  // SIMON 96/96 reference vector, most significant word first.
  localparam logic [95:0] TV_KEY = 96'h0d0c0b0a0908_050403020100;
  localparam logic [95:0] TV_PT  = 96'h2072616c6c69_702065687420;
  localparam logic [95:0] TV_CT  = 96'h602807a462b4_69063d8ff082;

endpackage

// File: rtl/simon_slot_reg.sv
// One output slot to the cipher core: holds a frame with newX raised until the core acks it.
`timescale 1ns/1ps
module simon_slot_reg
  import simon_loader_pkg::*;
#(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             nR,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  slot_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_HOLD;
      SLOT_HOLD:  if (ack)  state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Output register only moves while empty, so the core sees a stable value during HOLD.
  always_ff @(posedge clk) begin
    if (nR) begin
      state_q <= SLOT_EMPTY;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      if (load && (state_q == SLOT_EMPTY)) dout <= din;
    end
  end

  assign busy = (state_q == SLOT_HOLD);

endmodule

// File: rtl/simon_word_loader.sv
// Assembles a W-bit word stream into SIMON data blocks and keys, one frame of buffering per slot.
`timescale 1ns/1ps
module simon_word_loader
  import simon_loader_pkg::*;
#(
  parameter int N = 48,
  parameter int M = 2,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_word,
  input  logic                in_is_key,
  input  logic                in_enc_dec,
  output logic [1:0][N-1:0]   blockIN,
  output logic [M-1:0][N-1:0] KEY,
  output logic                enc_dec,
  output logic                newData,
  output logic                newKey,
  input  logic                loadData,
  input  logic                loadKey,
  output logic                err_frame
);

  localparam int DW     = calc_dw(N, W);
  localparam int KW     = calc_kw(N, M, W);
  localparam int DATA_W = 2 * N;
  localparam int KEY_W  = M * N;
  localparam int ASM_W  = (DATA_W > KEY_W) ? DATA_W : KEY_W;
  localparam int MAXW   = (DW > KW) ? DW : KW;
  localparam int CNT_W  = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DW - 1);
  localparam logic [CNT_W-1:0] KW_LAST = CNT_W'(KW - 1);

  asm_state_t         asm_q, asm_d;
  logic [ASM_W-1:0]   asm_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic [CNT_W-1:0]   idx;
  logic               cur_key, cur_enc;
  logic               pend_q, pend_d;
  logic               err_q, enc_q;
  logic               accept, abort, first, word_key, last;
  logic               tgt_busy, word_tgt_busy, xfer, xfer_data, xfer_key;
  logic [DATA_W-1:0]  data_q;
  logic [KEY_W-1:0]   key_q;

  assign accept   = in_valid && in_ready;
  assign abort    = accept && (cnt_p0 != '0) && (in_is_key != cur_key);
  assign first    = (cnt_p0 == '0) || abort;
  assign word_key = first ? in_is_key : cur_key;
  assign idx      = first ? '0 : cnt_p0;
  assign last     = accept && (idx == (word_key ? KW_LAST : DW_LAST));

  // cur_key still names the completed frame until the next frame's word 0 lands,
  // which at the earliest coincides with the transfer edge.
  assign word_tgt_busy = word_key ? newKey : newData;
  assign tgt_busy      = cur_key ? newKey : newData;
  assign xfer          = pend_q || ((asm_q == ASM_FULL) && !tgt_busy);
  assign xfer_data     = xfer && !cur_key;
  assign xfer_key      = xfer && cur_key;

  assign in_ready = (asm_q != ASM_FULL);

  always_comb begin
    asm_d  = asm_q;
    pend_d = 1'b0;
    case (asm_q)
      ASM_COLLECT: begin
        if (last) begin
          if (word_tgt_busy) asm_d = ASM_FULL;
          else               pend_d = 1'b1;
        end
      end
      ASM_FULL: if (!tgt_busy) asm_d = ASM_COLLECT;
      default:  asm_d = ASM_COLLECT;
    endcase
  end

  // Stage p0: word shift-in, frame counter and per-frame attributes.
  always_ff @(posedge clk) begin
    if (nR) begin
      asm_q   <= ASM_COLLECT;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_p0  <= '0;
      cur_key <= 1'b0;
      cur_enc <= 1'b0;
      asm_p0  <= '0;
      enc_q   <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      pend_q <= pend_d;
      err_q  <= abort;
      if (accept) begin
        asm_p0 <= (asm_p0 << W) | ASM_W'(in_word);
        cnt_p0 <= last ? '0 : (idx + CNT_W'(1));
        if (first) begin
          cur_key <= in_is_key;
          cur_enc <= in_enc_dec;
        end
      end
      if (xfer_data) enc_q <= cur_enc;
    end
  end

  // Stage p1: per-type output slots towards the core.
  simon_slot_reg #(.WIDTH(DATA_W)) u_data_slot (
    .clk  (clk),
    .nR   (nR),
    .load (xfer_data),
    .din  (asm_p0[DATA_W-1:0]),
    .ack  (loadData),
    .dout (data_q),
    .busy (newData)
  );

  simon_slot_reg #(.WIDTH(KEY_W)) u_key_slot (
    .clk  (clk),
    .nR   (nR),
    .load (xfer_key),
    .din  (asm_p0[KEY_W-1:0]),
    .ack  (loadKey),
    .dout (key_q),
    .busy (newKey)
  );

  assign blockIN   = data_q;
  assign KEY       = key_q;
  assign enc_dec   = enc_q;
  assign err_frame = err_q;

endmodule

// File: doc/simon_word_loader.md
Name: simon_word_loader

Overview:
- Upstream feeder for the SIMON 96/96 core.
- Accepts a narrow W-bit word stream over a valid/ready handshake and assembles each frame into a full 2N-bit plaintext/ciphertext block or an M*N-bit key.
- Presents completed frames on the core's blockIN/KEY inputs, raising newData/newKey and holding them until the core acknowledges with loadData/loadKey.
- Decouples the host bus width from the 96-bit cipher interface, with one frame of buffering.

Parameters:
- N, 48, cipher word size in bits
- M, 2, number of key words
- W, 16, input stream word width; 2N and M*N must both be multiples of W
- DW, 2*N/W, words per data frame (derived, not overridable)
- KW, M*N/W, words per key frame (derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- nR  in  1  reset; synchronous, active-high (nR=1 resets on the clock edge)
- in_valid  in  1  host word valid
- in_ready  out  1  loader can accept a word this cycle
- in_word  in  W  host word; the first word of a frame is the most significant
- in_is_key  in  1  1 = word belongs to a key frame, 0 = data frame
- in_enc_dec  in  1  direction for a data frame; sampled with word 0 only
- blockIN  out  [1:0][N-1:0]  assembled data block to the core
- KEY  out  [M-1:0][N-1:0]  assembled key to the core
- enc_dec  out  1  direction registered alongside blockIN
- newData  out  1  blockIN valid, waiting for the core
- newKey  out  1  KEY valid, waiting for the core
- loadData  in  1  core has taken blockIN
- loadKey  in  1  core has taken KEY
- err_frame  out  1  one-cycle pulse when a partial frame is aborted

Behaviour:
- Reset: in_ready=1; blockIN=0, KEY=0, enc_dec=0, newData=0, newKey=0, err_frame=0. Word counter, assembly register and asm_full flag are cleared.
- Reset mid-frame or mid-hold drops everything; there is no resumption.
- Word acceptance: a word is accepted on an edge where in_valid && in_ready.
- On acceptance, the assembly register shifts left by W and in_word enters the LSBs. The counter increments. in_is_key and in_enc_dec are latched on word 0.
- Frame length is DW words for data and KW words for a key.
- Type switch mid-frame: a word with in_is_key different from the latched type while cnt != 0 aborts the partial frame. err_frame=1 for the next cycle. The offending word is accepted as word 0 of a new frame.
- Completion: the last word is accepted at edge k.
  - If the target slot is free (newX=0), then at edge k+1 the output register loads the assembled value, newX=1, and enc_dec is updated for data frames. in_ready stays 1.
  - Otherwise asm_full=1 and in_ready=0 until the transfer happens.
- Hold: blockIN/KEY/enc_dec are stable while newX=1.
- Release: on an edge where newX && loadX, newX clears.
- Pending transfer: a pending asm_full frame transfers on the first edge with newX=0. newX is therefore low for at least one cycle between back-to-back frames of the same type.
- Data and key slots are independent. A full key frame may sit pending while a data frame transfers, and the reverse also holds.
- loadX while newX=0 is ignored.
- Counter wraps to 0 after each completion or abort.
- Combinational paths:
  - in_ready = !asm_full.
  - No combinational path exists from loadX to any output.
- FSM per slot: EMPTY -> (frame complete) -> HOLD -> (loadX) -> EMPTY.
- Assembly FSM: COLLECT -> (last word, slot busy) -> FULL -> (slot EMPTY) -> COLLECT.

Decomposition:
- Package simon_loader_pkg holds:
  - the state enum
  - DW/KW derivation functions
  - the SIMON 96/96 test-vector constants shared with the bench
- One natural sub-module: simon_slot_reg. It holds one output register, the newX/loadX handshake and EMPTY/HOLD state. It is instantiated twice, with width 2N and width M*N.

Test Plan:
- Key load: 6 words 0x0d0c,0x0b0a,0x0908,0x0504,0x0302,0x0100 with in_is_key=1 -> newKey=1 one cycle after word 6, KEY[1]=0x0d0c0b0a0908, KEY[0]=0x050403020100. Pulse loadKey -> newKey=0 next edge.
- Data load: words 0x2072,0x616c,0x6c69,0x7020,0x6568,0x7420 with enc_dec=1 -> blockIN[1]=0x2072616c6c69, blockIN[0]=0x702065687420, enc_dec=1. Feed the core and check output 0x602807a462b4/0x69063d8ff082.
- Backpressure: two data frames back-to-back with loadData held 0 -> in_ready=0 after frame 2's last word and blockIN unchanged. loadData=1 -> newData low one cycle, then high with frame 2 contents and in_ready=1.
- Type abort: 3 data words, then 1 key word -> err_frame pulse, partial data discarded. 5 more key words -> newKey with the 6 key words, newData never raised.
- Reset mid-frame: 4 words, nR=1 for one cycle, then a full fresh frame -> output contains only the fresh 6 words, with no trace of the first 4.
- Slot independence: key frame pending (newKey=1, loadKey=0) while a data frame completes -> newData=1 with the correct block, and KEY stays stable.
